// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; pop data is registered on rd_en (1 cycle).
// Writes when full and reads when empty are ignored; count never over/underflows.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wr_en,
    input  logic                    i_rd_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = cnt_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_rd_data;
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// FIFO-buffered UART transmitter; start bit appears the cycle after a pop, frames run back-to-back.
// din_ready = !full from the registered count; a same-cycle pop does not free a slot.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1085,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [DATA_WIDTH-1:0]        i_din,
    input  logic                         i_din_valid,
    output logic                         o_din_ready,
    output logic                         o_serial_tx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);
    localparam int      BAUD_W = cnt_w(CLKS_PER_BIT);
    localparam int      BIT_W  = cnt_w(DATA_WIDTH);
    localparam parity_e LP_PAR = parity_e'(2'(PARITY_MODE));

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_buf: PARITY_MODE must be 0, 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_buf: DATA_WIDTH must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_buf: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_buf: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buf: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e             r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_baud_end;
    logic                  w_last_stop;
    logic                  w_pre_last;
    logic [DATA_WIDTH-1:0] w_rd_data;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_din_valid),
        .i_rd_en   (w_pop),
        .i_wr_data (i_din),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (o_fifo_count)
    );

    assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_state == STOP) && (r_bit == BIT_W'(STOP_BITS - 1)) && w_baud_end;
    // done is registered, so it is raised one cycle ahead of the final stop cycle.
    assign w_pre_last  = (r_state == STOP) && (r_bit == BIT_W'(STOP_BITS - 1))
                         && (r_baud == BAUD_W'(CLKS_PER_BIT - 2));
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_last_stop);

    assign o_din_ready = !w_full;
    assign o_serial_tx = r_tx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_pre_last;
            r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    // The popped word is stable in the FIFO output register by now.
                    if (w_baud_end) begin
                        r_bit   <= '0;
                        r_tx    <= w_rd_data[0];
                        r_shift <= w_rd_data >> 1;
                        r_par   <= (^w_rd_data) ^ (LP_PAR == PAR_ODD);
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                            r_bit <= '0;
                            if (LP_PAR == PAR_NONE) begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_state <= PARITY;
                                r_tx    <= r_par;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_baud_end) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        if (r_bit == BIT_W'(STOP_BITS - 1)) begin
                            r_bit <= '0;
                            if (w_pop) begin
                                r_state <= START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Five transmitter configurations share clock and reset; a line monitor per instance decodes
// frames against a queue of accepted words.
module tb_uart_tx_buf;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] din [N];
    logic       dv  [N];
    wire        rdy [N];
    wire        tx  [N];
    wire        bsy [N];
    wire        dn  [N];
    wire  [2:0] cnt [N];

    int         vecs = 0;
    int         miss = 0;
    int         cyc  = 0;
    logic [8:0] q        [N][$];
    int         st_q     [N][$];
    logic [2:0] dcnt_q   [N][$];
    int         fr_ok    [N];
    int         dcnt     [N];
    int         last_done[N];
    int         nstall;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // inst0: 8N1   inst1: 8E1   inst2: 8O1   inst3: 8N2   inst4: 7N1 at 5 clks/bit
    function automatic int cw(input int k);   return (k == 4) ? 7 : 8; endfunction
    function automatic int cpar(input int k); return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
    function automatic int cstop(input int k); return (k == 3) ? 2 : 1; endfunction
    function automatic int ccpb(input int k); return (k == 4) ? 5 : 4; endfunction

    uart_tx_buf #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_clk(clk), .i_reset(rst), .i_din(din[0][7:0]), .i_din_valid(dv[0]), .o_din_ready(rdy[0]),
        .o_serial_tx(tx[0]), .o_busy(bsy[0]), .o_done(dn[0]), .o_fifo_count(cnt[0]));
    uart_tx_buf #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_clk(clk), .i_reset(rst), .i_din(din[1][7:0]), .i_din_valid(dv[1]), .o_din_ready(rdy[1]),
        .o_serial_tx(tx[1]), .o_busy(bsy[1]), .o_done(dn[1]), .o_fifo_count(cnt[1]));
    uart_tx_buf #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_clk(clk), .i_reset(rst), .i_din(din[2][7:0]), .i_din_valid(dv[2]), .o_din_ready(rdy[2]),
        .o_serial_tx(tx[2]), .o_busy(bsy[2]), .o_done(dn[2]), .o_fifo_count(cnt[2]));
    uart_tx_buf #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_clk(clk), .i_reset(rst), .i_din(din[3][7:0]), .i_din_valid(dv[3]), .o_din_ready(rdy[3]),
        .o_serial_tx(tx[3]), .o_busy(bsy[3]), .o_done(dn[3]), .o_fifo_count(cnt[3]));
    uart_tx_buf #(.DATA_WIDTH(7), .CLKS_PER_BIT(5), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .i_clk(clk), .i_reset(rst), .i_din(din[4][6:0]), .i_din_valid(dv[4]), .o_din_ready(rdy[4]),
        .o_serial_tx(tx[4]), .o_busy(bsy[4]), .o_done(dn[4]), .o_fifo_count(cnt[4]));

    // Decode one frame per start bit; each bit must hold for exactly ccpb(k) cycles.
    task automatic mon(input int k);
        logic [8:0]  w;
        logic [15:0] fb;
        logic        p, bad, aborted, g_tx, g_dn, g_bsy;
        int          nb, w_n, cpb;
        forever begin
            @(negedge clk);
            if (rst || tx[k] !== 1'b0) continue;
            st_q[k].push_back(cyc);
            w_n = cw(k);
            cpb = ccpb(k);
            if (q[k].size() == 0) begin
                vecs++; miss++;
                $display("FAIL unexpected_frame inst%0d cycle %0d: got start bit, want idle line", k, cyc);
                w = '0;
            end else begin
                w = q[k].pop_front();
            end
            fb = '1;
            fb[0] = 1'b0;
            p = 1'b0;
            for (int i = 0; i < w_n; i++) begin
                fb[1 + i] = w[i];
                p = p ^ w[i];
            end
            if (cpar(k) == 1) fb[1 + w_n] = p;
            if (cpar(k) == 2) fb[1 + w_n] = ~p;
            nb = 1 + w_n + ((cpar(k) != 0) ? 1 : 0) + cstop(k);
            aborted = 1'b0;
            for (int b = 0; b < nb && !aborted; b++) begin
                bad = 1'b0; g_tx = 1'b0; g_dn = 1'b0; g_bsy = 1'b0;
                for (int c = 0; c < cpb && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) aborted = 1'b1;
                    else if (!bad && (tx[k] !== fb[b] || bsy[k] !== 1'b1 ||
                                      dn[k] !== (b == nb - 1 && c == cpb - 1))) begin
                        bad = 1'b1; g_tx = tx[k]; g_dn = dn[k]; g_bsy = bsy[k];
                    end
                end
                if (!aborted) begin
                    vecs++;
                    if (bad) begin
                        miss++;
                        $display("FAIL frame_bit inst%0d word %h bit %0d: got tx=%b busy=%b done=%b, want tx=%b busy=1 done=%b",
                                 k, w, b, g_tx, g_bsy, g_dn, fb[b], (b == nb - 1));
                    end
                end
            end
            if (!aborted) fr_ok[k]++;
        end
    endtask

    task automatic done_watch();
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (dn[k] === 1'b1) begin
                    dcnt[k]++;
                    last_done[k] = cyc;
                    dcnt_q[k].push_back(cnt[k]);
                end
            end
        end
    endtask

    // Holds din_valid until every word is accepted; the scoreboard learns a word only on handshake.
    task automatic send(input int k, input logic [8:0] ws [8], input int n);
        int i = 0;
        int t = 0;
        logic [8:0] mask;
        mask = (cw(k) == 7) ? 9'h07F : 9'h0FF;
        while (i < n && t < 2000) begin
            @(posedge clk); #1;
            din[k] = ws[i] & mask;
            dv[k]  = 1'b1;
            vecs++;
            if (rdy[k] !== (cnt[k] != 3'd4)) begin
                miss++;
                $display("FAIL din_ready inst%0d: got %b with fifo_count=%0d, want %b", k, rdy[k], cnt[k], (cnt[k] != 3'd4));
            end
            if (rdy[k] === 1'b1) begin
                q[k].push_back(din[k]);
                i++;
            end else begin
                nstall++;
            end
            t++;
        end
        @(posedge clk); #1;
        dv[k] = 1'b0;
        if (i < n) begin
            vecs++; miss++;
            $display("FAIL send_timeout inst%0d: got %0d words accepted, want %0d", k, i, n);
        end
    endtask

    task automatic wait_frames(input int k, input int target);
        int t = 0;
        while (!(fr_ok[k] >= target && bsy[k] === 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        vecs++;
        if (fr_ok[k] < target || bsy[k] !== 1'b0 || tx[k] !== 1'b1) begin
            miss++;
            $display("FAIL wait_idle inst%0d: got frames=%0d busy=%b tx=%b, want frames=%0d busy=0 tx=1",
                     k, fr_ok[k], bsy[k], tx[k], target);
        end
    endtask

    task automatic check_len(input string nm, input int k, input int want);
        int got;
        got = last_done[k] - st_q[k][st_q[k].size() - 1] + 1;
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s inst%0d frame length: got %0d cycles, want %0d", nm, k, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            vecs++;
            if (tx[k] !== 1'b1 || bsy[k] !== 1'b0 || dn[k] !== 1'b0 || cnt[k] !== 3'd0 || rdy[k] !== 1'b1) begin
                miss++;
                $display("FAIL reset_state inst%0d: got tx=%b busy=%b done=%b count=%0d ready=%b, want 1 0 0 0 1",
                         k, tx[k], bsy[k], dn[k], cnt[k], rdy[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [8:0] ws [8];
        int d0;
        ws = '{default: 9'h0};
        ws[0] = 9'h0A7;
        d0 = dcnt[0];
        send(0, ws, 1);
        wait_frames(0, 1);
        check_len("single_8n1", 0, 40);
        vecs++;
        if (dcnt[0] - d0 !== 1) begin
            miss++;
            $display("FAIL single_done_count: got %0d pulses, want 1", dcnt[0] - d0);
        end
    endtask

    task automatic test_parity();
        logic [8:0] ws [8];
        ws = '{default: 9'h0};
        ws[0] = 9'h0A7;
        send(1, ws, 1);
        wait_frames(1, 1);
        check_len("parity_even", 1, 44);
        send(2, ws, 1);
        wait_frames(2, 1);
        check_len("parity_odd", 2, 44);
    endtask

    task automatic test_back_to_back();
        logic [8:0] ws [8];
        int base, d0;
        ws = '{default: 9'h0};
        ws[0] = 9'h001; ws[1] = 9'h002; ws[2] = 9'h003;
        base = st_q[3].size();
        d0 = dcnt[3];
        dcnt_q[3].delete();
        send(3, ws, 3);
        wait_frames(3, 3);
        for (int i = 1; i < 3; i++) begin
            vecs++;
            if (st_q[3].size() < base + 3 || st_q[3][base + i] - st_q[3][base + i - 1] !== 44) begin
                miss++;
                $display("FAIL b2b_spacing frame %0d: got %0d cycles, want 44", i,
                         (st_q[3].size() < base + 3) ? -1 : st_q[3][base + i] - st_q[3][base + i - 1]);
            end
        end
        vecs++;
        if (dcnt[3] - d0 !== 3) begin
            miss++;
            $display("FAIL b2b_done_count: got %0d, want 3", dcnt[3] - d0);
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (dcnt_q[3].size() <= i || dcnt_q[3][i] !== 3'(2 - i)) begin
                miss++;
                $display("FAIL b2b_fifo_count at done %0d: got %0d, want %0d", i,
                         (dcnt_q[3].size() <= i) ? -1 : int'(dcnt_q[3][i]), 2 - i);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [8:0] ws [8];
        int f0;
        ws = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h0, 9'h0};
        f0 = fr_ok[0];
        nstall = 0;
        send(0, ws, 6);
        vecs++;
        if (nstall !== 37) begin
            miss++;
            $display("FAIL stall_cycles: got %0d cycles with din_ready low, want 37", nstall);
        end
        wait_frames(0, f0 + 6);
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] ws [8];
        int d0, f0, s0;
        ws = '{9'h011, 9'h022, 9'h033, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        send(1, ws, 3);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        d0 = dcnt[1];
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if (tx[1] !== 1'b1 || cnt[1] !== 3'd0 || bsy[1] !== 1'b0 || dn[1] !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid_frame: got tx=%b count=%0d busy=%b done=%b, want 1 0 0 0",
                     tx[1], cnt[1], bsy[1], dn[1]);
        end
        q[1].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        f0 = fr_ok[1];
        s0 = st_q[1].size();
        repeat (60) @(negedge clk);
        vecs++;
        if (dcnt[1] !== d0 || st_q[1].size() !== s0) begin
            miss++;
            $display("FAIL reset_flush: got %0d done pulses and %0d starts after reset, want 0 and 0",
                     dcnt[1] - d0, st_q[1].size() - s0);
        end
        ws[0] = 9'h05A;
        send(1, ws, 1);
        wait_frames(1, f0 + 1);
        check_len("after_reset", 1, 44);
    endtask

    task automatic test_width7();
        logic [8:0] ws [8];
        ws = '{default: 9'h0};
        ws[0] = 9'h055;
        send(4, ws, 1);
        wait_frames(4, 1);
        check_len("width7", 4, 45);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            din[k] = '0;
            dv[k] = 1'b0;
            fr_ok[k] = 0;
            dcnt[k] = 0;
            last_done[k] = 0;
        end
        nstall = 0;
        fork
            mon(0); mon(1); mon(2); mon(3); mon(4);
            done_watch();
        join_none
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_full_stall();
        test_reset_mid_frame();
        test_width7();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
